// File: rtl/instr_mem.sv
// Instruction memory for the single-cycle MIPS32 core.
// Combinational read of a DEPTH x 32 array indexed by pc[ADDR_W+1:2], with a
// built-in default program that is reloaded asynchronously while rst_n is low.
// There is a synchronous write port for the bench or a program loader.
// Optional macro REG_OUT_EN registers instruction/addr_err/misaligned, which
// adds one cycle of latency. These registers clear to 0 on reset.
module instr_mem #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              addr_err,
    output logic              misaligned,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata
);

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_instr_d;
    logic              rd_err_d;
    logic              rd_mis_d;

    // Built-in boot program; every word past w7 is a NOP.
    function automatic logic [31:0] default_word(input int unsigned idx);
        logic [31:0] w;
        case (idx)
            0:       w = 32'h2008_0005; // addi $t0,$0,5
            1:       w = 32'h2009_000A; // addi $t1,$0,10
            2:       w = 32'h0109_5020; // add  $t2,$t0,$t1
            3:       w = 32'hAC0A_0000; // sw   $t2,0($0)
            4:       w = 32'h8C0B_0000; // lw   $t3,0($0)
            5:       w = 32'h116A_0001; // beq  $t3,$t2,+1
            7:       w = 32'h0800_0000; // j    0
            default: w = '0;
        endcase
        return w;
    endfunction

    // Storage: asynchronous reload of the default image; writes apply only out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= default_word(i);
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational fetch: word select, range check and alignment flag.
    always_comb begin
        word_idx   = pc[ADDR_W+1:2];
        rd_err_d   = |pc[31:ADDR_W+2];
        rd_mis_d   = |pc[1:0];
        rd_instr_d = rd_err_d ? '0 : mem_q[word_idx];
    end

`ifdef REG_OUT_EN
    logic [31:0] instr_q;
    logic        err_q;
    logic        mis_q;

    // Output registers: one cycle of fetch latency, cleared while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            instr_q <= rd_instr_d;
            err_q   <= rd_err_d;
            mis_q   <= rd_mis_d;
        end
    end

    assign instruction = instr_q;
    assign addr_err    = err_q;
    assign misaligned  = mis_q;
`else
    assign instruction = rd_instr_d;
    assign addr_err    = rd_err_d;
    assign misaligned  = rd_mis_d;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem in its default (combinational read) build.
// The model is a plain word array. It is updated on accepted writes and
// reloaded on reset. A negedge compare process checks every cycle against it.
module tb_instr_mem;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       pc;
    logic [31:0]       instruction;
    logic              addr_err;
    logic              misaligned;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] boot_img  [8] = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020,
                                   32'hAC0A_0000, 32'h8C0B_0000, 32'h116A_0001,
                                   32'h0000_0000, 32'h0800_0000};

    always #5 clk = ~clk;

    instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .instruction(instruction),
        .addr_err   (addr_err),
        .misaligned (misaligned),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++)
            model_mem[i] = (i < 8) ? boot_img[i] : 32'h0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1)
            model_mem[waddr] = wdata;
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        if (a >= 32'(DEPTH * 4)) return 32'h0;
        return model_mem[a / 4];
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
        return (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic exp_mis(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: pc=%h got %h expected %h", name, $time, pc, got, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_instr", instruction, exp_instr(pc));
            check("cyc_addr_err", {31'b0, addr_err}, {31'b0, exp_err(pc)});
            check("cyc_misaligned", {31'b0, misaligned}, {31'b0, exp_mis(pc)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; we = 1'b0; pc = '0; waddr = '0; wdata = '0;
        #12;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Default program after reset.
        for (int i = 0; i < 8; i++) begin
            pc = 32'(i * 4);
            #1;
            check("boot_word", instruction, boot_img[i]);
            check("boot_err", {31'b0, addr_err}, 32'h0);
            check("boot_mis", {31'b0, misaligned}, 32'h0);
        end

        // Misaligned pc still returns the containing word.
        pc = 32'h1; #1; check("mis1_word", instruction, 32'h2008_0005); check("mis1_flag", {31'b0, misaligned}, 32'h1);
        pc = 32'h2; #1; check("mis2_word", instruction, 32'h2008_0005); check("mis2_flag", {31'b0, misaligned}, 32'h1);
        pc = 32'h3; #1; check("mis3_word", instruction, 32'h2008_0005); check("mis3_flag", {31'b0, misaligned}, 32'h1);
        pc = 32'h5; #1; check("mis5_word", instruction, 32'h2009_000A); check("mis5_flag", {31'b0, misaligned}, 32'h1);

        // Range boundary.
        pc = 32'h100; #1; check("oob_word", instruction, 32'h0); check("oob_err", {31'b0, addr_err}, 32'h1);
        pc = 32'hFFFF_FFFC; #1; check("top_word", instruction, 32'h0); check("top_err", {31'b0, addr_err}, 32'h1);
        pc = 32'h0000_0103; #1; check("oob_mis", {31'b0, misaligned}, 32'h1); check("oob_mis_err", {31'b0, addr_err}, 32'h1);
        pc = 32'hFC; #1; check("last_word", instruction, 32'h0); check("last_err", {31'b0, addr_err}, 32'h0);

        // Read during write: old data before the edge, new data after it.
        tick();
        pc = 32'h24; we = 1'b1; waddr = 6'd9; wdata = 32'hDEAD_BEEF;
        #1; check("rdw_old", instruction, 32'h0);
        tick();
        we = 1'b0;
        check("rdw_new", instruction, 32'hDEAD_BEEF);
        tick();
        check("rdw_hold", instruction, 32'hDEAD_BEEF);

        // Asynchronous reset restores the image without a clock edge.
        pc = 32'h0; we = 1'b1; waddr = 6'd0; wdata = 32'h1234_5678;
        tick();
        we = 1'b0;
        check("w0_written", instruction, 32'h1234_5678);
        #2 rst_n = 1'b0;
        #1 check("async_reload", instruction, 32'h2008_0005);
        we = 1'b1; waddr = 6'd0; wdata = 32'hAAAA_5555;
        tick();
        check("write_in_reset", instruction, 32'h2008_0005);
        pc = 32'h24; #1;
        check("reset_clears_w9", instruction, 32'h0);
        we = 1'b0; rst_n = 1'b1;
        pc = 32'h0; #1;
        check("after_release", instruction, 32'h2008_0005);

        // Randomized traffic against the model.
        repeat (500) begin
            tick();
            case ($urandom % 4)
                0: pc = {24'h0, 2'b00, 6'($urandom % DEPTH)} << 0 ? 32'(($urandom % DEPTH) * 4) : 32'h0;
                1: pc = 32'($urandom % (DEPTH * 4));
                2: pc = $urandom;
                default: pc = 32'(DEPTH * 4) - 32'd8 + 32'($urandom % 16);
            endcase
            we    = ($urandom % 3) == 0;
            waddr = ADDR_W'($urandom);
            wdata = $urandom;
            if (($urandom % 60) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_async_reload", instruction, exp_instr(pc));
                rst_n = 1'b1;
            end
        end

        tick();
        we = 1'b0;
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
Instruction memory for the single-cycle MIPS32 core. Maps a 32-bit byte-address program counter to a 32-bit instruction word with an asynchronous (combinational) read. Holds a built-in default program, restored on reset. A synchronous write port lets the bench or a loader overwrite program words.

Parameters:
DEPTH, 64, number of 32-bit instruction words (power of two, 16..1024)
ADDR_W, 6, word-index width = log2(DEPTH)

Ports:
clk  input  1  write/register clock, rising edge
rst_n  input  1  asynchronous active-low reset; restores default program
pc  input  32  byte address of instruction to fetch
instruction  output  32  instruction word at pc
addr_err  output  1  1 when pc is outside memory (pc >= DEPTH*4)
misaligned  output  1  1 when pc[1:0] != 0
we  input  1  write enable, sampled on rising clk
waddr  input  ADDR_W  word index to write
wdata  input  32  word to write

Behaviour:
- Storage: DEPTH x 32-bit array.
- Word index = pc[ADDR_W+1:2]. pc[1:0] is ignored for data selection.
- Read is combinational. instruction changes in the same delta as pc or array contents, with no clock needed.
- Out of range: any pc[31:ADDR_W+2] bit set -> instruction = 32'h0000_0000 (NOP), addr_err = 1. Otherwise addr_err = 0.
- misaligned = |pc[1:0], independent of addr_err. It is a flag only; the word is still returned.
- Default image, loaded whenever rst_n is low:
  - w0 = 2008_0005 (addi $t0,$0,5)
  - w1 = 2009_000A (addi $t1,$0,10)
  - w2 = 0109_5020 (add $t2,$t0,$t1)
  - w3 = AC0A_0000 (sw $t2,0($0))
  - w4 = 8C0B_0000 (lw $t3,0($0))
  - w5 = 116A_0001 (beq $t3,$t2,+1)
  - w6 = 0000_0000
  - w7 = 0800_0000 (j 0)
  - all remaining words = 0
- Reset is asynchronous: asserting rst_n low immediately reloads the image, and instruction reflects the default word for the current pc in the same time step. While rst_n is low, writes are ignored.
- Write: on rising clk with rst_n high and we = 1, mem[waddr] <= wdata. waddr is always in range by width.
- Read during write to the same word: old data until the clk edge, new data immediately after it.
- Reset asserted in the same cycle as a write: reset wins, and the default value is kept.
- After reset, outputs are defined by pc alone. No X on instruction for any 2-state pc.

Optional Feature:
REG_OUT_EN:
- Defined: instruction, addr_err and misaligned are registered on rising clk, giving 1-cycle latency from pc. On rst_n low, all three are asynchronously cleared to 0. A read of a word written in the previous cycle returns the new data.
- Undefined: fully combinational outputs as specified above, with zero latency.

Test Plan:
- Reset then pc = 0,4,8,...,28 -> instruction = 20080005, 2009000A, 01095020, AC0A0000, 8C0B0000, 116A0001, 00000000, 08000000; addr_err = 0, misaligned = 0.
- pc = 1, 2, 3 -> instruction = 20080005, misaligned = 1. pc = 5 -> 2009000A, misaligned = 1.
- pc = 0x100 (DEPTH 64) and pc = 0xFFFF_FFFC -> instruction = 0, addr_err = 1. pc = 0xFC -> word 63 = 0, addr_err = 0.
- we = 1, waddr = 9, wdata = DEAD_BEEF at an edge; pc = 0x24 -> old value 0 before the edge, DEADBEEF after. The next cycle with we = 0 holds the value.
- Write 1234_5678 to word 0, then pulse rst_n low mid-cycle -> pc = 0 returns 20080005 immediately, not on the clock. A write attempted during reset is not stored.
- With REG_OUT_EN: pc steps 0 -> 4 -> instruction shows 20080005 then 2009000A, each one clk after the pc change. Reset forces instruction = 0.
